// File: rtl/pid_uk.sv
// Incremental PID stage: u(k) = u(k-1) + q0*e(k) + q1*e(k-1) + q2*e(k-2).
// One shared multiplier is time-multiplexed over three cycles, then the sum is clamped to N bits.
module pid_uk #(
  parameter int N = 25,
  parameter int F = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] ek,
  input  logic [N-1:0] q0,
  input  logic [N-1:0] q1,
  input  logic [N-1:0] q2,
  output logic [N-1:0] uk,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, SAT} state_t;

  state_t state, state_nxt;

  logic signed [N-1:0]   e0, e1, e2, u_prev;
  logic signed [N+2:0]   acc;
  logic signed [N-1:0]   mul_a, mul_b;
  logic signed [2*N-1:0] prod;
  logic signed [N+2:0]   term;
  logic signed [N-1:0]   u_sat;

  // Arithmetic shift floors toward -inf; the cast keeps the low N+3 bits.
  function automatic logic signed [N+2:0] trunc_prod(input logic signed [2*N-1:0] p);
    return (N+3)'(p >>> F);
  endfunction

  // In range exactly when the bits above the N-bit sign position all match the sign.
  function automatic logic signed [N-1:0] sat_acc(input logic signed [N+2:0] a);
    if (a[N+2:N-1] == {4{a[N+2]}})
      return a[N-1:0];
    else if (a[N+2])
      return {1'b1, {(N-1){1'b0}}};
    else
      return {1'b0, {(N-1){1'b1}}};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_a     = q0;
    mul_b     = e0;
    case (state)
      IDLE: if (start) state_nxt = MUL0;
      MUL0: state_nxt = MUL1;
      MUL1: begin
        state_nxt = MUL2;
        mul_a     = q1;
        mul_b     = e1;
      end
      MUL2: begin
        state_nxt = SAT;
        mul_a     = q2;
        mul_b     = e2;
      end
      SAT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign prod  = (2*N)'(mul_a) * (2*N)'(mul_b);
  assign term  = trunc_prod(prod);
  assign u_sat = sat_acc(acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      uk     <= '0;
      e0     <= '0;
      e1     <= '0;
      e2     <= '0;
      u_prev <= '0;
      acc    <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          e0   <= ek;
          acc  <= {{3{u_prev[N-1]}}, u_prev};
          busy <= 1'b1;
        end
        MUL0, MUL1, MUL2: acc <= acc + term;
        SAT: begin
          // History keeps the clamped value so the integrator cannot wind up.
          uk     <= u_sat;
          u_prev <= u_sat;
          e2     <= e1;
          e1     <= e0;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_uk.sv
// Bench for pid_uk: directed vector table, protocol corner sequences, and random samples
// checked against an arithmetic model of the incremental PID law.
module tb_pid_uk;
  localparam int N = 25;
  localparam int F = 16;
  localparam longint UMAX = (longint'(1) << (N-1)) - 1;
  localparam longint UMIN = -(longint'(1) << (N-1));

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic signed [N-1:0] ek = '0, q0 = '0, q1 = '0, q2 = '0;
  logic        [N-1:0] uk;
  logic                busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  longint m_u, m_e1, m_e2;

  pid_uk #(.N(N), .F(F)) dut (
    .clk(clk), .reset(reset), .start(start), .ek(ek),
    .q0(q0), .q1(q1), .q2(q2), .uk(uk), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit     rst;
    longint e, a, b, c;
    longint exp_u;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint suk();
    return longint'($signed(uk));
  endfunction

  task automatic model_reset();
    m_u = 0; m_e1 = 0; m_e2 = 0;
  endtask

  // u = u_prev + sum of floor(q*e / 2^F), clamped to the N-bit signed range.
  task automatic model_step(input longint e, a, b, c, output longint u);
    u = m_u + ((a * e) >>> F) + ((b * m_e1) >>> F) + ((c * m_e2) >>> F);
    if (u > UMAX) u = UMAX;
    if (u < UMIN) u = UMIN;
    m_u = u; m_e2 = m_e1; m_e1 = e;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start = 1'(($urandom));
      ek = N'($urandom); q0 = N'($urandom); q1 = N'($urandom); q2 = N'($urandom);
      step();
    end
    reset = 1'b0;
    start = 1'b0;
    check("reset_uk", suk(), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    model_reset();
  endtask

  // Issues one start, checks busy/done timing, returns uk seen with done.
  task automatic run_sample(input longint e, a, b, c, output longint got);
    ek = N'(e); q0 = N'(a); q1 = N'(b); q2 = N'(c);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) begin
        start = 1'b0;
        ek = N'($urandom);
      end
      check($sformatf("busy_e%0d", i), longint'(busy), 1);
      check($sformatf("done_e%0d", i), longint'(done), 0);
    end
    step();
    check("done_e4", longint'(done), 1);
    check("busy_e4", longint'(busy), 0);
    got = suk();
  endtask

  function automatic longint rnd(input int unsigned half);
    return longint'($urandom_range(2*half, 0)) - longint'(half);
  endfunction

  initial begin
    longint got, exp_u;
    int dones;

    vecs[0] = '{1, 32768, 65536, 0, 0, 32768};
    vecs[1] = '{0, 32768, 65536, 0, 0, 65536};
    vecs[2] = '{0, 32768, 65536, 0, 0, 98304};
    vecs[3] = '{1, 65536, 0, 65536, 131072, 0};
    vecs[4] = '{0, 0, 0, 65536, 131072, 65536};
    vecs[5] = '{0, 0, 0, 65536, 131072, 196608};
    vecs[6] = '{1, 131072, 200*65536, 0, 0, 16777215};
    vecs[7] = '{0, 65536, -65536, 0, 0, 16711679};
    vecs[8] = '{1, 131072, -200*65536, 0, 0, -16777216};
    vecs[9] = '{1, -1, 1, 0, 0, -1};

    step();
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].rst) do_reset();
      run_sample(vecs[v].e, vecs[v].a, vecs[v].b, vecs[v].c, got);
      model_step(vecs[v].e, vecs[v].a, vecs[v].b, vecs[v].c, exp_u);
      check($sformatf("vec%0d_uk", v), got, vecs[v].exp_u);
    end

    // uk must hold between samples
    repeat (3) step();
    check("hold_uk", suk(), -1);
    check("hold_done", longint'(done), 0);

    // start held high through edges 0..3 must yield exactly one done
    do_reset();
    ek = 32768; q0 = 65536; q1 = 0; q2 = 0;
    start = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) ek = N'($urandom);
      if (i == 3) start = 1'b0;
      if (done) dones++;
    end
    check("busy_start_dones", longint'(dones), 1);
    check("busy_start_uk", suk(), 32768);

    // reset in MUL1 discards the computation and clears history
    do_reset();
    run_sample(65536, 65536, 65536, 65536, got);
    check("pre_abort_uk", got, 65536);
    ek = 65536; start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) dones++;
    end
    check("abort_dones", longint'(dones), 0);
    check("abort_uk", suk(), 0);
    check("abort_busy", longint'(busy), 0);
    model_reset();
    run_sample(32768, 65536, 65536, 65536, got);
    check("post_abort_uk", got, 32768);
    model_step(32768, 65536, 65536, 65536, exp_u);

    // random back-to-back samples against the model
    do_reset();
    for (int k = 0; k < 40; k++) begin
      longint e, a, b, c;
      e = rnd(1 << 20); a = rnd(1 << 20); b = rnd(1 << 20); c = rnd(1 << 20);
      run_sample(e, a, b, c, got);
      model_step(e, a, b, c, exp_u);
      check($sformatf("rand%0d_uk", k), got, exp_u);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
